// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, line/frame strobes and delay-aligned VGA sync/blank
module vga_timing_gen #(
  parameter int   H_ACTIVE     = 800,
  parameter int   H_FP         = 56,
  parameter int   H_SYNC       = 120,
  parameter int   H_BP         = 64,
  parameter int   V_ACTIVE     = 600,
  parameter int   V_FP         = 37,
  parameter int   V_SYNC       = 6,
  parameter int   V_BP         = 23,
  parameter logic HS_POL       = 1'b1,
  parameter logic VS_POL       = 1'b1,
  parameter int   DELAY        = 2,
  parameter int   CNTR_WIDTH_H = 11,
  parameter int   CNTR_WIDTH_V = 10
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic                    inDisplayArea,
  output logic                    LineStart,
  output logic                    FrameStart,
  output logic [7:0]              FrameCount,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WH = CNTR_WIDTH_H + 1;
  localparam int WV = CNTR_WIDTH_V + 1;

  // One extra bit on the compare constants so a sync end equal to 2^W cannot alias to zero.
  localparam logic [WH-1:0] X_LAST   = WH'(H_TOTAL - 1);
  localparam logic [WH-1:0] X_ACT    = WH'(H_ACTIVE);
  localparam logic [WH-1:0] X_HS_ON  = WH'(H_ACTIVE + H_FP);
  localparam logic [WH-1:0] X_HS_OFF = WH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [WV-1:0] Y_LAST   = WV'(V_TOTAL - 1);
  localparam logic [WV-1:0] Y_ACT    = WV'(V_ACTIVE);
  localparam logic [WV-1:0] Y_VS_ON  = WV'(V_ACTIVE + V_FP);
  localparam logic [WV-1:0] Y_VS_OFF = WV'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (1 << CNTR_WIDTH_H)) begin : g_chk_h
    $fatal(1, "H_TOTAL does not fit in CNTR_WIDTH_H");
  end
  if (V_TOTAL > (1 << CNTR_WIDTH_V)) begin : g_chk_v
    $fatal(1, "V_TOTAL does not fit in CNTR_WIDTH_V");
  end
  if (DELAY < 1 || DELAY > 8) begin : g_chk_d
    $fatal(1, "DELAY must be in 1..8");
  end

  logic [CNTR_WIDTH_H-1:0] r_cnt_x;
  logic [CNTR_WIDTH_V-1:0] r_cnt_y;
  logic [7:0]              r_frame_cnt;
  logic [DELAY-1:0]        r_hs_sr;
  logic [DELAY-1:0]        r_vs_sr;
  logic [DELAY-1:0]        r_bn_sr;

  logic [WH-1:0] w_x_ext;
  logic [WV-1:0] w_y_ext;
  logic          w_x_wrap;
  logic          w_y_wrap;
  logic          w_disp;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic [DELAY:0] w_hs_in;
  logic [DELAY:0] w_vs_in;
  logic [DELAY:0] w_bn_in;

  assign w_x_ext  = {1'b0, r_cnt_x};
  assign w_y_ext  = {1'b0, r_cnt_y};
  assign w_x_wrap = (w_x_ext == X_LAST);
  assign w_y_wrap = (w_y_ext == Y_LAST);
  assign w_disp   = (w_x_ext < X_ACT) && (w_y_ext < Y_ACT);
  assign w_hs_raw = ((w_x_ext >= X_HS_ON) && (w_x_ext < X_HS_OFF)) ? HS_POL : ~HS_POL;
  assign w_vs_raw = ((w_y_ext >= Y_VS_ON) && (w_y_ext < Y_VS_OFF)) ? VS_POL : ~VS_POL;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt_x     <= '0;
      r_cnt_y     <= '0;
      r_frame_cnt <= '0;
    end else if (w_x_wrap) begin
      r_cnt_x <= '0;
      if (w_y_wrap) begin
        r_cnt_y     <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_cnt_y <= r_cnt_y + CNTR_WIDTH_V'(1);
      end
    end else begin
      r_cnt_x <= r_cnt_x + CNTR_WIDTH_H'(1);
    end
  end

  // Bit 0 of each *_in vector is the undelayed value; the chain shifts it up one stage per clock.
  assign w_hs_in = {r_hs_sr, w_hs_raw};
  assign w_vs_in = {r_vs_sr, w_vs_raw};
  assign w_bn_in = {r_bn_sr, w_disp};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hs_sr <= {DELAY{~HS_POL}};
      r_vs_sr <= {DELAY{~VS_POL}};
      r_bn_sr <= '0;
    end else begin
      r_hs_sr <= w_hs_in[DELAY-1:0];
      r_vs_sr <= w_vs_in[DELAY-1:0];
      r_bn_sr <= w_bn_in[DELAY-1:0];
    end
  end

  assign CounterX      = r_cnt_x;
  assign CounterY      = r_cnt_y;
  assign FrameCount    = r_frame_cnt;
  assign inDisplayArea = w_disp;
  assign LineStart     = (r_cnt_x == '0);
  assign FrameStart    = (r_cnt_x == '0) && (r_cnt_y == '0);
  assign VGA_HS        = r_hs_sr[DELAY-1];
  assign VGA_VS        = r_vs_sr[DELAY-1];
  assign VGA_BLANK_N   = r_bn_sr[DELAY-1];
  assign VGA_SYNC_N    = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 800x600@72 Hz raster for the 50 MHz display path. Free-running horizontal and vertical counters drive the CounterX/CounterY inputs of the image locator stage. Sync and blank outputs for the video DAC are delayed by a configurable pipeline depth so they line up with pixel data leaving the locator-plus-ROM path. The block also provides frame/line strobes and a frame counter for animation and highlight logic.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, active level of VGA_HS
- VS_POL, 1, active level of VGA_VS
- DELAY, 2, cycles from counter value to VGA_HS/VGA_VS/VGA_BLANK_N; legal range 1..8
- CNTR_WIDTH_H, 11, CounterX width
- CNTR_WIDTH_V, 10, CounterY width

Ports:
- CLK  in  1  pixel clock (50 MHz)
- RST_N  in  1  reset; one clock; synchronous, active-low
- CounterX  out  CNTR_WIDTH_H  current horizontal position
- CounterY  out  CNTR_WIDTH_V  current vertical position
- inDisplayArea  out  1  CounterX < H_ACTIVE and CounterY < V_ACTIVE; undelayed
- LineStart  out  1  one-cycle strobe when CounterX == 0
- FrameStart  out  1  one-cycle strobe when CounterX == 0 and CounterY == 0
- FrameCount  out  8  completed-frame counter
- VGA_HS  out  1  horizontal sync, delayed DELAY cycles
- VGA_VS  out  1  vertical sync, delayed DELAY cycles
- VGA_BLANK_N  out  1  display-area flag, delayed DELAY cycles
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (666).
- CounterX increments every cycle and wraps H_TOTAL-1 -> 0.
- CounterY increments only in the cycle where CounterX wraps, and itself wraps V_TOTAL-1 -> 0.
- FrameCount increments (mod 256) in the cycle where both counters wrap.
- Raw HS is active for H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC (856..975).
- Raw VS is active for V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC (637..642). It switches with CounterY, i.e. at CounterX == 0.
- Raw blank_n = inDisplayArea.
- {HS, VS, blank_n} pass through a DELAY-stage register shift chain. The last stage drives the VGA_* outputs; HS/VS are driven at the active level set by HS_POL/VS_POL.
- inDisplayArea, LineStart and FrameStart are decoded combinationally from the registered counters; they are not delayed.
- Counter arithmetic is unsigned. Parameter sets where H_TOTAL > 2^CNTR_WIDTH_H or V_TOTAL > 2^CNTR_WIDTH_V are illegal and flagged by an elaboration-time check.
- Reset, sampled on a rising CLK edge with RST_N = 0:
  - CounterX = 0, CounterY = 0, FrameCount = 0.
  - Every shift-chain stage is loaded with its inactive value: HS = ~HS_POL, VS = ~VS_POL, blank_n = 0.
  - Reset mid-frame aborts the frame immediately. No partial sync pulse continues past the reset edge.
- First cycle after RST_N returns high:
  - Counters are (0,0), so FrameStart = 1 and LineStart = 1.
  - VGA_* outputs stay inactive for DELAY cycles, then follow the counters.

## Timing
- Reset values while RST_N is low (outputs settle one edge after sampling):
  - CounterX = 0, CounterY = 0, FrameCount = 0.
  - inDisplayArea = 1, LineStart = 1, FrameStart = 1 (decoded from (0,0)).
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, VGA_BLANK_N = 0, VGA_SYNC_N = 0.
- Latency: VGA_* at edge t reflect counter state at edge t-DELAY.
  - The default DELAY = 2 covers the locator's registered ROM_Addr plus the registered ROM output.
- Line period: 1040 cycles. Frame period: 692 640 cycles.
- LineStart: 666 pulses per frame. FrameStart: 1 pulse per frame, coincident with a LineStart.
- All outputs are glitch-free register outputs or decodes of registers. No combinational path exists from any input to any output except through CLK.

## Test plan
- Reset release: hold RST_N = 0 for 5 cycles, then release -> counters (0,0); FrameStart = 1 on the first cycle; VGA_BLANK_N = 0 for exactly 2 cycles, then 1; VGA_HS = 0 and VGA_VS = 0.
- Horizontal timing: run one line -> VGA_HS high for exactly 120 cycles, rising 856+2 cycles after LineStart; VGA_BLANK_N high for 800 cycles per visible line; CounterX wraps 1039 -> 0 while CounterY steps 0 -> 1.
- Vertical timing: run a full frame -> VGA_VS high for exactly 6×1040 = 6240 cycles, starting when CounterY = 637 (plus 2-cycle delay); VGA_BLANK_N stays low for lines 600..665; FrameStart interval = 692 640 cycles.
- Frame counter wrap: run 256 frames (or force FrameCount = 255 via hierarchy) -> FrameCount goes 255 -> 0 in the cycle (X,Y) = (1039,665) -> (0,0).
- Mid-frame reset: assert RST_N = 0 while CounterX = 900, CounterY = 640 (both syncs active) -> next edge: counters = (0,0), VGA_HS = 0, VGA_VS = 0, VGA_BLANK_N = 0; after release, normal timing restarts from (0,0).
- DELAY = 5 build: repeat the horizontal test -> every VGA_* edge is shifted by exactly 5 cycles from the matching counter value; counter-side outputs are unchanged.
